cpu_eu_param: RTL

- Parametrised next-generation CPU execution unit: register file, ALU with registered N/Z/C/V flags, PC, IR, link register and a memory-access engine using a req/ack handshake.
- Driven cycle-by-cycle by the control unit.
- Widens the fixed 16-bit/8-register datapath to configurable width and depth.
- Adds call/return and wait-state-tolerant memory access, signalled back through busy/done.

---
 rtl/cpu_eu_pkg.sv | 37 +++
 rtl/cpu_eu_param_regfile.sv | 40 ++++
 rtl/cpu_eu_param.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/cpu_eu_pkg.sv
// Shared encodings for the parametrised execution unit: ALU functions,
// PC source selects and the memory-engine state machine.
package cpu_eu_pkg;

  typedef enum logic [3:0] {
    ALU_R    = 4'd0,
    ALU_S    = 4'd1,
    ALU_ADD  = 4'd2,
    ALU_SUB  = 4'd3,
    ALU_AND  = 4'd4,
    ALU_OR   = 4'd5,
    ALU_XOR  = 4'd6,
    ALU_NOT  = 4'd7,
    ALU_INC  = 4'd8,
    ALU_DEC  = 4'd9,
    ALU_SHL  = 4'd10,
    ALU_SHR  = 4'd11,
    ALU_ASR  = 4'd12,
    ALU_ROL  = 4'd13,
    ALU_ZERO = 4'd14,
    ALU_ONES = 4'd15
  } alu_op_e;

  typedef enum logic [1:0] {
    PC_REL  = 2'd0,
    PC_ALU  = 2'd1,
    PC_LR   = 2'd2,
    PC_HOLD = 2'd3
  } pc_sel_e;

  typedef enum logic [1:0] {
    MEM_IDLE = 2'd0,
    MEM_REQ  = 2'd1,
    MEM_DONE = 2'd2
  } mem_state_e;

endpackage

// File: rtl/cpu_eu_param_regfile.sv
// REG_CNT x DATA_W register file: one write port, two combinational read
// ports; a read of the register being written returns the old contents.
module regfile_param import cpu_eu_pkg::*; #(
  parameter int  DATA_W  = 16,
  parameter int  REG_CNT = 8,
  localparam int ADR_W   = (REG_CNT > 1) ? $clog2(REG_CNT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADR_W-1:0]  w_adr,
  input  logic [DATA_W-1:0] w_data,
  input  logic [ADR_W-1:0]  r_adr,
  output logic [DATA_W-1:0] r_data,
  input  logic [ADR_W-1:0]  s_adr,
  output logic [DATA_W-1:0] s_data
);

  logic [DATA_W-1:0] regs_q [REG_CNT];

  generate
    for (genvar gi = 0; gi < REG_CNT; gi++) begin : g_reg
      logic [DATA_W-1:0] q_reg;

      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          q_reg <= '0;
        end else if (w_en && (w_adr == ADR_W'(gi))) begin
          q_reg <= w_data;
        end
      end

      assign regs_q[gi] = q_reg;
    end
  endgenerate

  assign r_data = regs_q[r_adr];
  assign s_data = regs_q[s_adr];

endmodule

// File: rtl/cpu_eu_param.sv
// Parametrised CPU execution unit: register file, ALU with latched flags,
// PC/IR/LR and a req/ack memory engine, all steered by the control unit.
module cpu_eu_param import cpu_eu_pkg::*; #(
  parameter int               DATA_W   = 16,
  parameter int               REG_CNT  = 8,
  parameter int               OFS_W    = 8,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  localparam int              ADR_W    = (REG_CNT > 1) ? $clog2(REG_CNT) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              w_en,
  input  logic [ADR_W-1:0]  w_adr,
  input  logic [ADR_W-1:0]  r_adr,
  input  logic [ADR_W-1:0]  s_adr,
  input  logic [3:0]        alu_op,
  input  logic              s_sel,
  input  logic              flag_ld,
  input  logic              adr_sel,
  input  logic [1:0]        pc_sel,
  input  logic              pc_load,
  input  logic              pc_inc,
  input  logic              ir_load,
  input  logic              lr_save,
  input  logic              mem_start,
  input  logic              mem_we,
  output logic              mem_req,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              mem_done,
  output logic [DATA_W-1:0] ir_out,
  output logic [DATA_W-1:0] pc_out,
  output logic [DATA_W-1:0] d_out,
  output logic              n,
  output logic              z,
  output logic              c,
  output logic              v
);

  localparam int MSB = DATA_W - 1;

  logic [DATA_W-1:0] r_out, s_reg, s_op;
  logic [DATA_W-1:0] alu_res;
  logic              alu_c, alu_v;
  logic [DATA_W-1:0] pc_reg, pc_next, ir_reg, lr_reg, mdr_reg;
  logic [DATA_W-1:0] ofs_ext, address;
  logic              n_reg, z_reg, c_reg, v_reg;

  mem_state_e        state_reg;
  logic              mem_req_reg, mem_wr_reg, mem_done_reg, busy_reg;
  logic [DATA_W-1:0] mem_addr_reg, mem_wdata_reg;

  regfile_param #(
    .DATA_W  (DATA_W),
    .REG_CNT (REG_CNT)
  ) u_regfile (
    .clk    (clk),
    .reset  (reset),
    .w_en   (w_en),
    .w_adr  (w_adr),
    .w_data (alu_res),
    .r_adr  (r_adr),
    .r_data (r_out),
    .s_adr  (s_adr),
    .s_data (s_reg)
  );

  assign s_op = s_sel ? mdr_reg : s_reg;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_R:    alu_res = r_out;
      ALU_S:    alu_res = s_op;
      ALU_ADD: begin
        {alu_c, alu_res} = {1'b0, r_out} + {1'b0, s_op};
        alu_v = (r_out[MSB] == s_op[MSB]) && (alu_res[MSB] != r_out[MSB]);
      end
      ALU_SUB: begin
        // The extra top bit of the widened difference is the unsigned borrow.
        {alu_c, alu_res} = {1'b0, r_out} - {1'b0, s_op};
        alu_v = (r_out[MSB] != s_op[MSB]) && (alu_res[MSB] != r_out[MSB]);
      end
      ALU_AND:  alu_res = r_out & s_op;
      ALU_OR:   alu_res = r_out | s_op;
      ALU_XOR:  alu_res = r_out ^ s_op;
      ALU_NOT:  alu_res = ~r_out;
      ALU_INC: begin
        {alu_c, alu_res} = {1'b0, r_out} + (DATA_W + 1)'(1);
        alu_v = !r_out[MSB] && alu_res[MSB];
      end
      ALU_DEC: begin
        {alu_c, alu_res} = {1'b0, r_out} - (DATA_W + 1)'(1);
        alu_v = r_out[MSB] && !alu_res[MSB];
      end
      ALU_SHL: begin
        alu_res = {r_out[MSB-1:0], 1'b0};
        alu_c   = r_out[MSB];
      end
      ALU_SHR: begin
        alu_res = {1'b0, r_out[MSB:1]};
        alu_c   = r_out[0];
      end
      ALU_ASR: begin
        alu_res = {r_out[MSB], r_out[MSB:1]};
        alu_c   = r_out[0];
      end
      ALU_ROL: begin
        alu_res = {r_out[MSB-1:0], r_out[MSB]};
        alu_c   = r_out[MSB];
      end
      ALU_ZERO: alu_res = '0;
      ALU_ONES: alu_res = '1;
      default:  alu_res = '0;
    endcase
  end

  assign ofs_ext = DATA_W'($signed(ir_reg[OFS_W-1:0]));
  assign address = adr_sel ? r_out : pc_reg;

  always_comb begin
    pc_next = pc_reg;
    if (pc_load) begin
      case (pc_sel_e'(pc_sel))
        PC_REL:  pc_next = pc_reg + ofs_ext;
        PC_ALU:  pc_next = alu_res;
        PC_LR:   pc_next = lr_reg;
        PC_HOLD: pc_next = pc_reg;
        default: pc_next = pc_reg;
      endcase
    end else if (pc_inc) begin
      pc_next = pc_reg + DATA_W'(1);
    end
  end

  // LR samples the PC as it stands this cycle, so a call saves the pre-jump PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_reg <= RESET_PC;
      ir_reg <= '0;
      lr_reg <= '0;
      n_reg  <= 1'b0;
      z_reg  <= 1'b0;
      c_reg  <= 1'b0;
      v_reg  <= 1'b0;
    end else begin
      pc_reg <= pc_next;
      if (lr_save) lr_reg <= pc_reg;
      if (ir_load) ir_reg <= mdr_reg;
      if (flag_ld) begin
        n_reg <= alu_res[MSB];
        z_reg <= (alu_res == '0);
        c_reg <= alu_c;
        v_reg <= alu_v;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= MEM_IDLE;
      mem_req_reg   <= 1'b0;
      mem_wr_reg    <= 1'b0;
      mem_done_reg  <= 1'b0;
      busy_reg      <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      mdr_reg       <= '0;
    end else begin
      mem_done_reg <= 1'b0;
      case (state_reg)
        MEM_IDLE: begin
          if (mem_start) begin
            mem_addr_reg  <= address;
            mem_wdata_reg <= alu_res;
            mem_wr_reg    <= mem_we;
            mem_req_reg   <= 1'b1;
            busy_reg      <= 1'b1;
            state_reg     <= MEM_REQ;
          end
        end
        MEM_REQ: begin
          if (mem_ack) begin
            if (!mem_wr_reg) mdr_reg <= mem_rdata;
            mem_req_reg  <= 1'b0;
            mem_done_reg <= 1'b1;
            state_reg    <= MEM_DONE;
          end
        end
        MEM_DONE: begin
          busy_reg  <= 1'b0;
          state_reg <= MEM_IDLE;
        end
        default: begin
          mem_req_reg <= 1'b0;
          busy_reg    <= 1'b0;
          state_reg   <= MEM_IDLE;
        end
      endcase
    end
  end

  assign mem_req   = mem_req_reg;
  assign mem_wr    = mem_wr_reg;
  assign mem_addr  = mem_addr_reg;
  assign mem_wdata = mem_wdata_reg;
  assign mem_done  = mem_done_reg;
  assign busy      = busy_reg;
  assign ir_out    = ir_reg;
  assign pc_out    = pc_reg;
  assign d_out     = alu_res;
  assign n         = n_reg;
  assign z         = z_reg;
  assign c         = c_reg;
  assign v         = v_reg;

endmodule
